hf_ssp_tx: RTL and testbench
============================

// Module: hf_ssp_tx
// PURPOSE
//  FPGA->ARM direction of the host link: buffers demodulated HF sample words and serializes them onto the SSP pins.
//  Generates ssp_clk/ssp_frame/ssp_din; the ARM SSP samples ssp_din on rising ssp_clk.
//  Shared by all HF major modes; the top-level mode mux selects whether its pins reach the output.
// PARAMETERS
//  WIDTH       8  bits per SSP word, MSB first
//  FIFO_DEPTH  4  word buffer entries (power of 2, >=2)
//  CLK_DIV     4  ck_1356meg cycles per ssp_clk half-period (>=1)
// PORTS
//  ck_1356meg  in   1      sole clock, 13.56 MHz
//  reset       in   1      asynchronous, active-high
//  tx_en       in   1      serializer enable (mode active)
//  data_in     in   WIDTH  word to send
//  data_valid  in   1      data_in valid this cycle
//  data_ready  out  1      FIFO can accept; push = data_valid & data_ready
//  overflow    out  1      sticky: data_valid seen while !data_ready
//  ssp_clk     out  1      serial clock to ARM
//  ssp_frame   out  1      high during the MSB bit cell of each word
//  ssp_din     out  1      serial data to ARM
// BEHAVIOUR
//  Reset: ssp_clk=0, ssp_frame=0, ssp_din=0, overflow=0, FIFO empty, data_ready=1, state IDLE, divider=0.
//  Divider: counts 0..CLK_DIV-1 while tx_en or state==SHIFT; ssp_clk toggles on wrap. Period = 2*CLK_DIV.
//  "Fall tick" = the cycle ssp_clk is registered 1->0; all serial outputs update only on fall ticks.
//  tx_en=0 in IDLE: divider held at 0, ssp_clk held 0; FIFO still accepts pushes.
//  FSM IDLE: on fall tick with FIFO non-empty and tx_en=1 -> pop, load shifter, ssp_frame=1, ssp_din=MSB, bitcnt=WIDTH-1 -> SHIFT.
//  FSM SHIFT: each fall tick: ssp_frame=0, shift next bit out, bitcnt--.
//   Fall tick ending last bit (bitcnt==0): FIFO non-empty and tx_en -> load next word back-to-back (frame=1, no gap);
//   else -> IDLE, ssp_din=0, ssp_frame=0.
//  tx_en dropped mid-word: current word completes, then IDLE; clock stops low. Never truncates a word.
//  Latency: word pushed into empty FIFO while IDLE+tx_en appears on ssp_din within 2*CLK_DIV+1 cycles.
//  FIFO: data_ready = ~full from registered count.
//   Push when full is rejected even if a pop occurs the same cycle; data dropped, overflow<=1 (until reset).
//   Simultaneous push+pop when not full: count unchanged, order preserved. Pointers wrap modulo FIFO_DEPTH.
//  Reset mid-word: outputs return to reset values immediately (async); partial word is lost, no trailing bits.
// CONFIGURATION
//  HF_SSP_TX_PARITY_EN defined: after LSB, one extra bit cell carrying odd parity of the word
//   (frame length WIDTH+1; back-to-back load happens after the parity cell).
//  Undefined: frame length exactly WIDTH, no parity logic present.
// STRUCTURE
//  hf_ssp_pkg: SSP_IDLE/SSP_SHIFT state encodings, default WIDTH/FIFO_DEPTH/CLK_DIV constants, bit-counter width.
//  Sub-module hf_ssp_fifo (sync FIFO, same clock/reset, count-based full/empty).
//  Divider, FSM and shifter stay in hf_ssp_tx.
// TESTING
//  1 Defaults, tx_en=1, push 8'hA5 -> ssp_frame high exactly one ssp_clk period; ARM-side sampler on rising edge reads 1,0,1,0,0,1,0,1; ssp_din=0 after.
//  2 Push 8'h01,8'h80,8'hFF in consecutive cycles -> three frames back-to-back, no idle cell, bits correct, data_ready stays 1.
//  3 tx_en=0, push 5 words -> 4 accepted, data_ready=0, 5th dropped, overflow=1, ssp_clk flat 0; tx_en=1 -> exactly 4 words sent in order.
//  4 Full FIFO, push coincident with pop fall tick -> push rejected, overflow=1; next push accepted.
//  5 Assert reset during bit 3 of 8'h3C -> all outputs 0 same cycle, FIFO empty; after release no residual bits.
//  6 HF_SSP_TX_PARITY_EN, push 8'h07 -> 9-bit frame, 9th bit = 0 (odd parity); 8'h03 -> 9th bit 1.

Source files
------------

// File: rtl/hf_ssp_pkg.sv
// Shared types and defaults for the HF SSP transmit path (FPGA -> ARM).
package hf_ssp_pkg;

    localparam int SSP_WIDTH      = 8;
    localparam int SSP_FIFO_DEPTH = 4;
    localparam int SSP_CLK_DIV    = 4;

    typedef enum logic {
        SSP_IDLE  = 1'b0,
        SSP_SHIFT = 1'b1
    } ssp_state_t;

    // Counter width able to hold values 0..n-1 (never narrower than 1 bit).
    function automatic int ssp_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SSP_BITCNT_W = ssp_cnt_w(SSP_WIDTH + 1);

endpackage

// File: rtl/hf_ssp_fifo.sv
// Synchronous word FIFO with count-based full/empty; rejects pushes when full.
module hf_ssp_fifo
    import hf_ssp_pkg::*;
#(
    parameter int WIDTH = SSP_WIDTH,
    parameter int DEPTH = SSP_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = ssp_cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hf_ssp_tx.sv
// HF sample words -> SSP serializer (ssp_clk/ssp_frame/ssp_din), MSB first.
// Define HF_SSP_TX_PARITY_EN to append an odd-parity bit cell after each word.
module hf_ssp_tx
    import hf_ssp_pkg::*;
#(
    parameter int WIDTH      = SSP_WIDTH,
    parameter int FIFO_DEPTH = SSP_FIFO_DEPTH,
    parameter int CLK_DIV    = SSP_CLK_DIV
) (
    input  logic             ck_1356meg,
    input  logic             reset,
    input  logic             tx_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             overflow,
    output logic             ssp_clk,
    output logic             ssp_frame,
    output logic             ssp_din
);

`ifdef HF_SSP_TX_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = ssp_cnt_w(FRAME);
    localparam int DW = ssp_cnt_w(CLK_DIV);

    ssp_state_t       state;
    ssp_state_t       state_nx;
    logic [DW-1:0]    div;
    logic [CW-1:0]    bitcnt;
    logic [FRAME-1:0] shreg;
    logic [FRAME-1:0] load_word;
    logic [WIDTH-1:0] fifo_rdata;
    logic             full;
    logic             empty;
    logic             run;
    logic             wrap;
    logic             fall;
    logic             load;
    logic             shift;
    logic             finish;

    hf_ssp_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (ck_1356meg),
        .reset (reset),
        .push  (data_valid),
        .wdata (data_in),
        .pop   (load),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty)
    );

    assign data_ready = ~full;

`ifdef HF_SSP_TX_PARITY_EN
    assign load_word = {fifo_rdata, ~^fifo_rdata};
`else
    assign load_word = fifo_rdata;
`endif

    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset)                  overflow <= 1'b0;
        else if (data_valid & full) overflow <= 1'b1;
    end

    // Clock keeps running while a word is in flight so it always completes.
    assign run  = tx_en | (state == SSP_SHIFT);
    assign wrap = (div == DW'(CLK_DIV - 1));
    assign fall = run & wrap & ssp_clk;

    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) begin
            div     <= '0;
            ssp_clk <= 1'b0;
        end else if (!run) begin
            div     <= '0;
            ssp_clk <= 1'b0;
        end else if (wrap) begin
            div     <= '0;
            ssp_clk <= ~ssp_clk;
        end else begin
            div     <= div + DW'(1);
        end
    end

    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) state <= SSP_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        shift    = 1'b0;
        finish   = 1'b0;
        unique case (state)
            SSP_IDLE: begin
                if (fall && tx_en && !empty) begin
                    load     = 1'b1;
                    state_nx = SSP_SHIFT;
                end
            end
            SSP_SHIFT: begin
                if (fall) begin
                    if (bitcnt != '0) begin
                        shift = 1'b1;
                    end else if (tx_en && !empty) begin
                        load = 1'b1;
                    end else begin
                        finish   = 1'b1;
                        state_nx = SSP_IDLE;
                    end
                end
            end
            default: state_nx = SSP_IDLE;
        endcase
    end

    // shreg top bit is the cell currently on ssp_din.
    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            bitcnt    <= '0;
            ssp_frame <= 1'b0;
            ssp_din   <= 1'b0;
        end else if (load) begin
            shreg     <= load_word;
            bitcnt    <= CW'(FRAME - 1);
            ssp_frame <= 1'b1;
            ssp_din   <= load_word[FRAME-1];
        end else if (shift) begin
            shreg     <= shreg << 1;
            bitcnt    <= bitcnt - CW'(1);
            ssp_frame <= 1'b0;
            ssp_din   <= shreg[FRAME-2];
        end else if (finish) begin
            ssp_frame <= 1'b0;
            ssp_din   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hf_ssp_tx.sv
// Directed bench for hf_ssp_tx: scoreboard queue filled by stimulus,
// drained by an ARM-side monitor sampling ssp_din on rising ssp_clk.
module tb_hf_ssp_tx;

    localparam int W  = 8;
    localparam int CD = 4;
`ifdef HF_SSP_TX_PARITY_EN
    localparam int FR = W + 1;
`else
    localparam int FR = W;
`endif

    typedef struct {
        logic [FR-1:0] bits;
        bit            chk_gap;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         tx_en;
    logic [W-1:0] data_in;
    logic         data_valid;
    logic         data_ready;
    logic         overflow;
    logic         ssp_clk;
    logic         ssp_frame;
    logic         ssp_din;

    exp_t         expq[$];
    int           checks = 0;
    int           fails  = 0;

    bit           in_word = 0;
    int           idx     = 0;
    int           gap     = 0;
    int           last_gap = 0;
    int           flen    = 0;
    logic [FR-1:0] sh;
    logic         prev_clk;

    hf_ssp_tx dut (
        .ck_1356meg (clk),
        .reset      (reset),
        .tx_en      (tx_en),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overflow   (overflow),
        .ssp_clk    (ssp_clk),
        .ssp_frame  (ssp_frame),
        .ssp_din    (ssp_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [FR-1:0] frame_of(input logic [W-1:0] w);
`ifdef HF_SSP_TX_PARITY_EN
        return {w, ~^w};
`else
        return w;
`endif
    endfunction

    task automatic expect_word(input logic [FR-1:0] b, input bit g);
        exp_t e;
        e.bits    = b;
        e.chk_gap = g;
        expq.push_back(e);
    endtask

    task automatic push(input logic [W-1:0] w);
        data_valid = 1'b1;
        data_in    = w;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        expq.delete();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((expq.size() != 0 || in_word) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check({name, "_drain_in_time"}, (n < 3000), 1);
        repeat (4 * CD) @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input string name, input int target);
        int n;
        n = 0;
        while (idx != target && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check({name, "_bit_reached"}, (idx == target), 1);
    endtask

    // ARM-side sampler plus frame-width checker.
    initial begin
        exp_t e;
        prev_clk = 1'b0;
        sh       = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_word  = 0;
                idx      = 0;
                flen     = 0;
                gap      = 0;
                prev_clk = 1'b0;
            end else begin
                if (ssp_frame) begin
                    flen++;
                end else if (flen != 0) begin
                    check("frame_len", flen, 2 * CD);
                    flen = 0;
                end
                if (ssp_clk && !prev_clk) begin
                    if (ssp_frame) begin
                        check("frame_mid_word", in_word, 0);
                        in_word  = 1;
                        idx      = 0;
                        last_gap = gap;
                        gap      = 0;
                    end
                    if (in_word) begin
                        sh = {sh[FR-2:0], ssp_din};
                        idx++;
                        if (idx == FR) begin
                            in_word = 0;
                            idx     = 0;
                            if (expq.size() == 0) begin
                                checks++;
                                fails++;
                                $display("FAIL unexpected_word: got %0h, required none", sh);
                            end else begin
                                e = expq.pop_front();
                                check("word", sh, e.bits);
                                if (e.chk_gap) check("b2b_gap", last_gap, 0);
                            end
                        end
                    end else begin
                        gap++;
                    end
                end
                prev_clk = ssp_clk;
            end
        end
    end

    initial begin
        bit ok;
        reset      = 1'b1;
        tx_en      = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ssp_clk", ssp_clk, 0);
        check("rst_frame", ssp_frame, 0);
        check("rst_din", ssp_din, 0);
        check("rst_overflow", overflow, 0);
        check("rst_ready", data_ready, 1);
        reset = 1'b0;

        // single word
        tx_en = 1'b1;
        expect_word(frame_of(8'hA5), 0);
        push(8'hA5);
        drain("t1");
        check("t1_din_after", ssp_din, 0);
        check("t1_frame_after", ssp_frame, 0);

        // back-to-back words
        ok = 1;
        expect_word(frame_of(8'h01), 0);
        expect_word(frame_of(8'h80), 1);
        expect_word(frame_of(8'hFF), 1);
        push(8'h01);
        if (!data_ready) ok = 0;
        push(8'h80);
        if (!data_ready) ok = 0;
        push(8'hFF);
        if (!data_ready) ok = 0;
        check("t2_ready_high", ok, 1);
        drain("t2");

        // fill while disabled, overflow, then release
        do_reset();
        tx_en = 1'b0;
        ok = 1;
        expect_word(frame_of(8'h11), 0);
        expect_word(frame_of(8'h22), 1);
        expect_word(frame_of(8'h33), 1);
        expect_word(frame_of(8'h44), 1);
        check("t3_ovf_before", overflow, 0);
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        check("t3_ready_full", data_ready, 0);
        push(8'h55);
        check("t3_overflow", overflow, 1);
        for (int i = 0; i < 20; i++) begin
            if (ssp_clk) ok = 0;
            @(posedge clk);
            #1;
        end
        check("t3_clk_flat", ok, 1);
        tx_en = 1'b1;
        drain("t3");
        check("t3_overflow_sticky", overflow, 1);

        // push rejected on the same edge as the first pop
        do_reset();
        tx_en = 1'b0;
        expect_word(frame_of(8'hA1), 0);
        expect_word(frame_of(8'hA2), 1);
        expect_word(frame_of(8'hA3), 1);
        expect_word(frame_of(8'hA4), 1);
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        push(8'hA4);
        tx_en = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("t4_ovf_pre", overflow, 0);
        check("t4_ready_pre", data_ready, 0);
        data_valid = 1'b1;
        data_in    = 8'hEE;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        check("t4_overflow", overflow, 1);
        check("t4_ready_post", data_ready, 1);
        expect_word(frame_of(8'h5A), 1);
        push(8'h5A);
        drain("t4");

        // reset during bit 3
        do_reset();
        tx_en = 1'b1;
        expect_word(frame_of(8'h3C), 0);
        push(8'h3C);
        wait_idx("t5", 4);
        #2;
        reset = 1'b1;
        #1;
        check("t5_clk", ssp_clk, 0);
        check("t5_frame", ssp_frame, 0);
        check("t5_din", ssp_din, 0);
        check("t5_ready", data_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        expq.delete();
        reset = 1'b0;
        ok = 1;
        for (int i = 0; i < 6 * 2 * CD; i++) begin
            if (ssp_din || ssp_frame) ok = 0;
            @(posedge clk);
            #1;
        end
        check("t5_no_residue", ok, 1);

        // enable dropped mid-word
        expect_word(frame_of(8'hC3), 0);
        push(8'hC3);
        wait_idx("t7", 2);
        tx_en = 1'b0;
        drain("t7");
        ok = 1;
        for (int i = 0; i < 20; i++) begin
            if (ssp_clk || ssp_frame || ssp_din) ok = 0;
            @(posedge clk);
            #1;
        end
        check("t7_stopped_low", ok, 1);

`ifdef HF_SSP_TX_PARITY_EN
        tx_en = 1'b1;
        expect_word(9'h00E, 0);
        expect_word(9'h007, 1);
        push(8'h07);
        push(8'h03);
        drain("t6");
`endif

        check("final_queue_empty", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
